arbiter_rr_lock: RTL and testbench
==================================

# arbiter_rr_lock

Parametrised round-robin input arbiter with packet (wormhole) locking for the credit-based router. It selects one of `N_PORTS` LBDR requests for a single output and holds the grant for the whole packet, head through tail. Grants are gated by downstream credit availability, and fairness rotates after every completed packet. It replaces the fixed-priority, per-flit arbiter in new router builds.

## Interface
- `N_PORTS`, default 5: number of requesters. Bit order is 0=N, 1=E, 2=W, 3=S, 4=L at the default. Legal range is 2..16.
- `IDX_W`, default `$clog2(N_PORTS)`: width of the index outputs. Derived; never overridden.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N_PORTS  per-port request from LBDR. The flit is valid at the input buffer head.
- `tail`  in  N_PORTS  per-port tail marker. Meaningful only with the matching `req` bit. A single-flit packet asserts it on the head flit.
- `credit_avail`  in  1  downstream credit counter is non-zero.
- `grant`  out  N_PORTS  one-hot grant, combinational from state and inputs. A transfer happens in any cycle where `|grant` is 1.
- `grant_valid`  out  1  equals `|grant`.
- `owner_id`  out  IDX_W  registered index of the locked owner. Holds its last value when unlocked.
- `locked`  out  1  registered; 1 while a multi-flit packet is in progress.

## Operation
- State registers:
  - `state`: IDLE or LOCKED.
  - `ptr` (IDX_W): round-robin start index.
  - `owner` (IDX_W): current packet owner.
- Reset values: state=IDLE, ptr=0, owner=0, so `locked`=0 and `owner_id`=0.
- Outputs during and right after reset: `grant` is forced to all-zero in any cycle where `reset`=1. After reset, `grant` depends only on the reset-valued state and the inputs.
- Winner search in IDLE:
  - Scan indices ptr, ptr+1, …, ptr+N_PORTS-1, each taken modulo N_PORTS. The first index with `req`=1 wins.
  - The modulo wrap must be correct for non-power-of-2 N_PORTS. Indices ≥ N_PORTS are never produced.
- IDLE:
  - With winner w and `credit_avail`=1: `grant[w]`=1.
  - If `tail[w]`=1 (single-flit packet): remain in IDLE, ptr ← (w+1) mod N_PORTS.
  - Otherwise: go to LOCKED, owner ← w. ptr is unchanged.
  - With no request or `credit_avail`=0: `grant`=0 and no state change.
- LOCKED:
  - `grant[owner]` = `req[owner]` & `credit_avail`. All other grant bits are 0, even if those ports request.
  - On a transfer with `tail[owner]`=1: go to IDLE, ptr ← (owner+1) mod N_PORTS.
  - If the owner drops `req` mid-packet (input buffer empty): `grant`=0 and the block stays LOCKED indefinitely. There is no timeout.
- Invalid state encodings: if `state` decodes to neither IDLE nor LOCKED, it recovers to IDLE on the next edge with no grant issued. Synthesis must not optimise away this recovery path.
- Reset mid-packet: on the next edge the block returns to IDLE, ptr=0, with the lock dropped. Discarding the partial packet is the router's responsibility.
- Invariants:
  - `grant` is at most one-hot.
  - `grant` is never 1 while `credit_avail`=0.
  - A granted bit always has its `req` bit set.

## Timing
- Grant latency: zero cycles. `grant` is valid in the same cycle as `req`/`credit_avail`, derived combinationally from registered state.
- State, ptr and owner update on the rising edge that ends a transfer cycle. The `locked` output rises in the cycle after a non-tail head transfer.
- The next packet can be granted in the cycle immediately after a tail transfer, so there is no bubble between packets.
- Throughput: one flit per cycle while the owner's `req`=1 and `credit_avail`=1.
- Worst-case wait for a requester: N_PORTS-1 complete packets.

## Test plan
- Reset and idle:
  - Stimulus: assert `reset` for 2 cycles with `req`=5'b11111.
  - Required: `grant`=0 during reset. `locked`=0 and `owner_id`=0 after reset. The first grant is 5'b00001.
- Round-robin rotation:
  - Stimulus: `req`=5'b11111, `tail`=5'b11111, `credit_avail`=1 for 6 cycles.
  - Required: grants 00001, 00010, 00100, 01000, 10000, 00001.
- Packet lock:
  - Stimulus: port 2 sends a 4-flit packet (tail on the 4th flit) while ports 0 and 4 request continuously.
  - Required: `grant`=00100 for 4 cycles, `locked`=1 through the tail cycle. Next grant is 10000 (ptr=3, first requester at or after 3).
- Credit stall and owner bubble:
  - Stimulus: mid-packet, drop `credit_avail` for 3 cycles, then drop the owner's `req` for 2 cycles.
  - Required: `grant`=0 in all 5 cycles, `locked` stays 1, `owner_id` unchanged, other requesters are not granted. The packet resumes afterwards.
- Non-power-of-2 wrap:
  - Stimulus: N_PORTS=3. Port 2 completes a single-flit packet, then `req`=3'b011.
  - Required: ptr wraps to 0 and `grant`=3'b001.
- Reset mid-packet:
  - Stimulus: assert `reset` for 1 cycle while locked on port 3.
  - Required: IDLE and ptr=0 after reset. With `req`=5'b11000 the grant is 01000 and `locked` is 0.

Source files
------------

// File: rtl/arbiter_rr_lock.sv
// Round-robin single-output arbiter with wormhole packet locking and
// downstream credit gating. Fairness pointer rotates after every completed packet.
module arbiter_rr_lock #(
  parameter int N_PORTS = 5,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] tail,
  input  logic               credit_avail,
  output logic [N_PORTS-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   owner_id,
  output logic               locked
);

  // One-hot encoding leaves two illegal codes that the default arm recovers from.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic [IDX_W-1:0] owner, owner_next;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_PORTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Scan from ptr upward, folding indices back below N_PORTS so that
  // non-power-of-2 port counts never produce an out-of-range winner.
  always_comb begin
    logic [IDX_W:0] cand;
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path can leave a value held (no inferred latch).
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_PORTS)) cand = cand - (IDX_W+1)'(N_PORTS);
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    grant      = '0;
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    case (state)
      ST_IDLE: begin
        if (win_found && credit_avail) begin
          grant[win_idx] = 1'b1;
          if (tail[win_idx]) begin
            ptr_next = next_idx(win_idx);
          end else begin
            state_next = ST_LOCKED;
            owner_next = win_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (req[owner] && credit_avail) begin
          grant[owner] = 1'b1;
          if (tail[owner]) begin
            state_next = ST_IDLE;
            ptr_next   = next_idx(owner);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (reset) grant = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      owner <= owner_next;
    end
  end

  assign grant_valid = |grant;
  assign owner_id    = owner;
  assign locked      = (state == ST_LOCKED);

endmodule

// File: tb/tb_arbiter_rr_lock.sv
// Self-checking bench for arbiter_rr_lock: directed scenarios plus randomized
// traffic against a packet-level reference model, at N_PORTS=5 and N_PORTS=3.
module tb_arbiter_rr_lock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] req, tail;
  logic       credit_avail;
  logic [4:0] grant;
  logic       grant_valid;
  logic [2:0] owner_id;
  logic       locked;

  logic       reset3;
  logic [2:0] req3, tail3;
  logic       credit3;
  logic [2:0] grant3;
  logic       grant_valid3;
  logic [1:0] owner_id3;
  logic       locked3;

  arbiter_rr_lock #(.N_PORTS(5)) dut5 (
    .clk(clk), .reset(reset), .req(req), .tail(tail), .credit_avail(credit_avail),
    .grant(grant), .grant_valid(grant_valid), .owner_id(owner_id), .locked(locked)
  );

  arbiter_rr_lock #(.N_PORTS(3)) dut3 (
    .clk(clk), .reset(reset3), .req(req3), .tail(tail3), .credit_avail(credit3),
    .grant(grant3), .grant_valid(grant_valid3), .owner_id(owner_id3), .locked(locked3)
  );

  int checks = 0;
  int errors = 0;

  // Packet-level reference model, index 0 = 5-port DUT, index 1 = 3-port DUT.
  int m_ptr [2];
  int m_own [2];
  bit m_lock[2];

  // Expected values for the cycle just driven (pre-edge view).
  logic [4:0] eg;
  logic       el;
  int         eo;

  function automatic int find_winner(input int ptr, input logic [4:0] r, input int n);
    for (int k = 0; k < n; k++) begin
      if (r[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  // Drive one cycle on DUT d (the other DUT is parked in reset), compute the
  // expected outputs for this cycle, then advance the model past the edge.
  task automatic cyc(input int d, input logic rst, input logic [4:0] r,
                     input logic [4:0] t, input logic c);
    int n;
    int w;
    logic [4:0] g;
    n = (d == 0) ? 5 : 3;
    @(negedge clk);
    if (d == 0) begin
      reset = rst; req = r; tail = t; credit_avail = c; reset3 = 1'b1;
    end else begin
      reset3 = rst; req3 = r[2:0]; tail3 = t[2:0]; credit3 = c; reset = 1'b1;
    end
    #1;
    g  = '0;
    w  = -1;
    el = m_lock[d];
    eo = m_own[d];
    if (!rst) begin
      if (m_lock[d]) begin
        if (r[m_own[d]] && c) begin g[m_own[d]] = 1'b1; w = m_own[d]; end
      end else begin
        w = find_winner(m_ptr[d], r, n);
        if (w >= 0 && c) g[w] = 1'b1;
        else w = -1;
      end
    end
    eg = g;
    if (rst) begin
      m_ptr[d] = 0; m_own[d] = 0; m_lock[d] = 1'b0;
    end else if (w >= 0) begin
      if (m_lock[d]) begin
        if (t[w]) begin m_lock[d] = 1'b0; m_ptr[d] = (w + 1) % n; end
      end else if (t[w]) begin
        m_ptr[d] = (w + 1) % n;
      end else begin
        m_lock[d] = 1'b1; m_own[d] = w;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1'b1, 5'b11111, 5'b11111, 1'b1);
      checks++;
      if (grant !== 5'b00000) begin
        errors++; $display("FAIL reset_grant[%0d] got=%b want=00000", i, grant);
      end
    end
    cyc(0, 1'b0, 5'b11111, 5'b11111, 1'b1);
    checks++;
    if (locked !== 1'b0 || owner_id !== 3'd0) begin
      errors++; $display("FAIL reset_state got locked=%b owner=%0d want 0/0", locked, owner_id);
    end
    checks++;
    if (grant !== 5'b00001 || grant !== eg) begin
      errors++; $display("FAIL reset_first_grant got=%b want=00001 model=%b", grant, eg);
    end
  endtask

  task automatic test_rotation();
    logic [4:0] exp_tab [6];
    exp_tab = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    cyc(0, 1'b1, 5'b00000, 5'b00000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1'b0, 5'b11111, 5'b11111, 1'b1);
      checks++;
      if (grant !== exp_tab[i] || grant !== eg || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation[%0d] got=%b valid=%b want=%b", i, grant, grant_valid, exp_tab[i]);
      end
    end
  endtask

  task automatic test_lock();
    cyc(0, 1'b1, 5'b00000, 5'b00000, 1'b1);
    cyc(0, 1'b0, 5'b00011, 5'b00011, 1'b1);  // single-flit on 0, ptr -> 1
    cyc(0, 1'b0, 5'b00010, 5'b00010, 1'b1);  // single-flit on 1, ptr -> 2
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b0, 5'b10101, (i == 3) ? 5'b00100 : 5'b00000, 1'b1);
      checks++;
      if (grant !== 5'b00100 || grant !== eg) begin
        errors++; $display("FAIL lock_grant[%0d] got=%b want=00100", i, grant);
      end
      checks++;
      if (locked !== (i != 0) || locked !== el || (i != 0 && owner_id !== 3'd2)) begin
        errors++;
        $display("FAIL lock_state[%0d] got locked=%b owner=%0d want locked=%b owner=2",
                 i, locked, owner_id, (i != 0));
      end
    end
    cyc(0, 1'b0, 5'b10001, 5'b10001, 1'b1);
    checks++;
    if (grant !== 5'b10000 || grant !== eg || locked !== 1'b0) begin
      errors++; $display("FAIL lock_next got=%b locked=%b want=10000 locked=0", grant, locked);
    end
  endtask

  task automatic test_stall();
    cyc(0, 1'b1, 5'b00000, 5'b00000, 1'b1);
    cyc(0, 1'b0, 5'b00010, 5'b00000, 1'b1);  // head on port 1
    for (int i = 0; i < 5; i++) begin
      if (i < 3) cyc(0, 1'b0, 5'b11111, 5'b00000, 1'b0);
      else       cyc(0, 1'b0, 5'b11101, 5'b00000, 1'b1);
      checks++;
      if (grant !== 5'b00000 || grant_valid !== 1'b0 || grant !== eg) begin
        errors++; $display("FAIL stall_grant[%0d] got=%b want=00000", i, grant);
      end
      checks++;
      if (locked !== 1'b1 || owner_id !== 3'd1) begin
        errors++; $display("FAIL stall_state[%0d] got locked=%b owner=%0d want 1/1", i, locked, owner_id);
      end
    end
    cyc(0, 1'b0, 5'b11111, 5'b00010, 1'b1);  // resume with tail
    checks++;
    if (grant !== 5'b00010 || locked !== 1'b1) begin
      errors++; $display("FAIL stall_resume got=%b locked=%b want=00010 locked=1", grant, locked);
    end
    cyc(0, 1'b0, 5'b11111, 5'b11111, 1'b1);
    checks++;
    if (grant !== 5'b00100 || grant !== eg || locked !== 1'b0) begin
      errors++; $display("FAIL stall_after got=%b locked=%b want=00100 locked=0", grant, locked);
    end
  endtask

  task automatic test_wrap3();
    cyc(1, 1'b1, 5'b00000, 5'b00000, 1'b1);
    cyc(1, 1'b0, 5'b00100, 5'b00100, 1'b1);
    checks++;
    if (grant3 !== 3'b100 || grant3 !== eg[2:0]) begin
      errors++; $display("FAIL wrap3_first got=%b want=100", grant3);
    end
    cyc(1, 1'b0, 5'b00011, 5'b00011, 1'b1);
    checks++;
    if (grant3 !== 3'b001 || grant3 !== eg[2:0] || locked3 !== 1'b0) begin
      errors++; $display("FAIL wrap3_wrap got=%b locked=%b want=001 locked=0", grant3, locked3);
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 1'b1, 5'b00000, 5'b00000, 1'b1);
    cyc(0, 1'b0, 5'b01000, 5'b00000, 1'b1);
    cyc(0, 1'b0, 5'b01000, 5'b00000, 1'b1);
    checks++;
    if (locked !== 1'b1 || owner_id !== 3'd3) begin
      errors++; $display("FAIL rstmid_locked got locked=%b owner=%0d want 1/3", locked, owner_id);
    end
    cyc(0, 1'b1, 5'b11000, 5'b00000, 1'b1);
    checks++;
    if (grant !== 5'b00000) begin
      errors++; $display("FAIL rstmid_during got=%b want=00000", grant);
    end
    cyc(0, 1'b0, 5'b11000, 5'b00000, 1'b1);
    checks++;
    if (grant !== 5'b01000 || grant !== eg || locked !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got=%b locked=%b want=01000 locked=0", grant, locked);
    end
  endtask

  task automatic test_random5();
    logic [4:0] r, t;
    logic       c, rst;
    cyc(0, 1'b1, 5'b00000, 5'b00000, 1'b1);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      r   = 5'($urandom);
      t   = 5'($urandom) & 5'($urandom);
      c   = ($urandom_range(0, 3) != 0);
      cyc(0, rst, r, t, c);
      checks++;
      if (grant !== eg || grant_valid !== (|eg) || locked !== el || owner_id !== eo[2:0]) begin
        errors++;
        $display("FAIL rand5[%0d] got g=%b v=%b l=%b o=%0d want g=%b l=%b o=%0d",
                 i, grant, grant_valid, locked, owner_id, eg, el, eo);
      end
      checks++;
      if ((grant & ~req) != 0 || !$onehot0(grant) || (!credit_avail && grant != 0)) begin
        errors++; $display("FAIL rand5_inv[%0d] got g=%b req=%b credit=%b", i, grant, req, credit_avail);
      end
    end
  endtask

  task automatic test_random3();
    logic [4:0] r, t;
    cyc(1, 1'b1, 5'b00000, 5'b00000, 1'b1);
    for (int i = 0; i < 200; i++) begin
      r = {2'b00, 3'($urandom)};
      t = {2'b00, 3'($urandom) & 3'($urandom)};
      cyc(1, 1'b0, r, t, ($urandom_range(0, 3) != 0));
      checks++;
      if (grant3 !== eg[2:0] || locked3 !== el || owner_id3 !== eo[1:0]) begin
        errors++;
        $display("FAIL rand3[%0d] got g=%b l=%b o=%0d want g=%b l=%b o=%0d",
                 i, grant3, locked3, owner_id3, eg[2:0], el, eo);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; tail = '0; credit_avail = 1'b0;
    reset3 = 1'b1; req3 = '0; tail3 = '0; credit3 = 1'b0;
    m_ptr = '{0, 0}; m_own = '{0, 0}; m_lock = '{1'b0, 1'b0};
    test_reset();
    test_rotation();
    test_lock();
    test_stall();
    test_wrap3();
    test_reset_mid();
    test_random5();
    test_random3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
